ex_muldiv_iter: RTL
===================

// Module: ex_muldiv_iter
// PURPOSE
//  Iterative RV32M multiply/divide unit, one result bit per cycle. Sits beside the EX stage ALU.
//  Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU op. Holds the pipeline via stall_req_o.
//  Returns the result with its write-back tag (wd/wreg) on a one-cycle done_o pulse.
//  XLEN-wide successor to the single-cycle ALU, with start/flush handshake and sign handling.
// PARAMETERS
//  XLEN        32  operand/result width (>=8, even)
//  REG_ADDR_W  5   destination register address width
// PORTS
//  clk          in   1           clock; all state updates on posedge
//  rst          in   1           synchronous reset, active-low (rst==0 resets at posedge)
//  start_i      in   1           request: op/operands/tag valid this cycle
//  flush_i      in   1           abort current op (branch/exception)
//  op_i         in   3           funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  opa_i        in   XLEN        rs1 value
//  opb_i        in   XLEN        rs2 value
//  wd_i         in   REG_ADDR_W  destination register
//  wreg_i       in   1           write-enable tag
//  result_o     out  XLEN        result, valid while done_o=1
//  wd_o         out  REG_ADDR_W  captured wd_i, valid while done_o=1
//  wreg_o       out  1           captured wreg_i, gated: 0 unless done_o=1
//  done_o       out  1           one-cycle completion pulse
//  busy_o       out  1           1 in CALC state
//  stall_req_o  out  1           combinational: (IDLE & start_i & ~flush_i) | CALC
// BEHAVIOUR
//  Reset: state=IDLE, all registered outputs and datapath regs = 0.
//  Reset also abandons any op in flight; no done_o follows.
//  States: IDLE -> CALC -> DONE -> IDLE. Shortcut path: IDLE -> DONE.
//  IDLE, start_i=1, flush_i=0 at edge T:
//   - latch op, tag, |a|, |b|; record result sign.
//   - |x| = two's-complement magnitude if the operand is treated signed and negative.
//   - Signed: opa for MULH/MULHSU/DIV/REM; opb for MULH/DIV/REM.
//   - Enter CALC with counter = XLEN.
//  CALC: one shift-add (mul) or restoring-subtract (div) step per cycle.
//   - Counter decrements each step; at counter==1 go to DONE.
//   - Normal latency: start edge T -> done_o high in cycle T+XLEN+1.
//  DONE: done_o=1 for exactly one cycle, result_o/wd_o/wreg_o valid; then IDLE.
//   - stall_req_o=0 in DONE, so EX/MEM captures the result that cycle.
//  Mul results from the 2*XLEN unsigned magnitude product P:
//   - negate P if the sign flag is set.
//   - MUL returns P[XLEN-1:0]; MULH/MULHSU/MULHU return P[2XLEN-1:XLEN].
//  Div results: quotient negated if operand signs differ (DIV); remainder takes dividend sign (REM).
//  Shortcut, result in cycle T+1, no CALC:
//   - opb==0: DIV/DIVU -> all ones; REM/REMU -> opa.
//   - Signed overflow (opa==MIN, opb==-1, DIV/REM): DIV -> MIN, REM -> 0.
//  flush_i=1 in any state: next state IDLE, no done_o, tag cleared. flush wins over start_i.
//  start_i while in CALC or DONE: ignored; EX must not present a new op until done_o.
//  Inputs are sampled only at the accepting edge; later changes do not affect the result.
// TESTING (XLEN=32)
//  MUL 7 x -3: done_o at T+33, result 0xFFFFFFEB; wd/wreg echoed; stall high T..T+32.
//  MULH 0x80000000 x 0x80000000 -> 0x40000000.
//  MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
//  MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
//  DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2. Each done at T+33.
//  Divide by zero: DIVU 5/0 -> 0xFFFFFFFF at T+1; REM 5/0 -> 5.
//  Overflow: DIV 0x80000000/-1 -> 0x80000000 at T+1; REM -> 0.
//  flush_i at T+10 of DIV: no done_o, busy_o=0 at T+11. New start at T+11 -> correct result at T+44.
//  rst=0 mid-CALC: outputs 0 next cycle, no done_o. start_i during CALC ignored, first result unchanged.

Source files
------------

// File: rtl/ex_muldiv_iter.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-subtract step per cycle.
// Holds the pipeline through stall_req_o and returns the result with its write-back tag on done_o.
module ex_muldiv_iter #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  flush_i,
  input  logic [2:0]            op_i,
  input  logic [XLEN-1:0]       opa_i,
  input  logic [XLEN-1:0]       opb_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  output logic [XLEN-1:0]       result_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic                  stall_req_o
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_n;

  logic [2:0]            op_q;
  logic [REG_ADDR_W-1:0] wd_q;
  logic                  wreg_q;
  logic [XLEN-1:0]       opd_q;   // multiplicand (mul) or divisor (div) magnitude
  logic [XLEN-1:0]       acc_q;   // product high half / partial remainder
  logic [XLEN-1:0]       lo_q;    // product low half / dividend shifting into quotient
  logic                  neg_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [XLEN-1:0]       result_q;

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] x, input logic n);
    return n ? ({XLEN{1'b0}} - x) : x;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] x, input logic n);
    return n ? ({(2*XLEN){1'b0}} - x) : x;
  endfunction

  // Operand decode for the accepting cycle
  logic            is_div_in, a_sgn, b_sgn, a_neg, b_neg, neg_in, div0, ovf, shortcut;
  logic [XLEN-1:0] a_mag, b_mag, short_res;

  always_comb begin
    is_div_in = op_i[2];
    a_sgn     = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
    b_sgn     = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
    a_neg     = a_sgn & opa_i[XLEN-1];
    b_neg     = b_sgn & opb_i[XLEN-1];
    a_mag     = neg_x(opa_i, a_neg);
    b_mag     = neg_x(opb_i, b_neg);
    // remainder follows the dividend; quotient and product follow the sign xor
    neg_in    = (is_div_in && op_i[1]) ? a_neg : (a_neg ^ b_neg);
    div0      = is_div_in && (opb_i == '0);
    ovf       = is_div_in && !op_i[0] && (opa_i == MIN_VAL) && (opb_i == '1);
    shortcut  = div0 || ovf;
    if (div0) short_res = op_i[1] ? opa_i : '1;
    else      short_res = op_i[1] ? '0 : MIN_VAL;
  end

  // One iteration step plus final sign fix-up
  logic [XLEN:0]     mul_sum, div_diff;
  logic [XLEN-1:0]   acc_n, lo_n, div_res, mul_res, fin_res;
  logic [2*XLEN-1:0] prod_s;

  always_comb begin
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opd_q} : {(XLEN+1){1'b0}});
    div_diff = {acc_q, lo_q[XLEN-1]} - {1'b0, opd_q};
    if (op_q[2]) begin
      acc_n = div_diff[XLEN] ? {acc_q[XLEN-2:0], lo_q[XLEN-1]} : div_diff[XLEN-1:0];
      lo_n  = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
    end else begin
      acc_n = mul_sum[XLEN:1];
      lo_n  = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod_s  = neg_2x({acc_n, lo_n}, neg_q);
    mul_res = (op_q == 3'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    div_res = op_q[1] ? neg_x(acc_n, neg_q) : neg_x(lo_n, neg_q);
    fin_res = op_q[2] ? div_res : mul_res;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_i && !flush_i) state_n = shortcut ? DONE : CALC;
      CALC:    if (cnt_q == CNT_W'(1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush_i) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q     <= '0;
      wd_q     <= '0;
      wreg_q   <= 1'b0;
      opd_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (flush_i) begin
      wd_q   <= '0;
      wreg_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          op_q   <= op_i;
          wd_q   <= wd_i;
          wreg_q <= wreg_i;
          opd_q  <= is_div_in ? b_mag : a_mag;
          lo_q   <= is_div_in ? a_mag : b_mag;
          acc_q  <= '0;
          neg_q  <= neg_in;
          cnt_q  <= CNT_W'(XLEN);
          if (shortcut) result_q <= short_res;
        end
        CALC: begin
          acc_q <= acc_n;
          lo_q  <= lo_n;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) result_q <= fin_res;
        end
        default: ;
      endcase
    end
  end

  assign done_o      = (state == DONE);
  assign busy_o      = (state == CALC);
  assign stall_req_o = ((state == IDLE) && start_i && !flush_i) || (state == CALC);
  assign result_o    = result_q;
  assign wd_o        = wd_q;
  assign wreg_o      = wreg_q & done_o;

endmodule
